// File: rtl/pixel_buffer_arbiter.sv
// pixel_buffer_arbiter: shares a single-port pixel buffer between a
// streaming writer and a random-address reader. One RAM access per cycle,
// round-robin on contention, sequential write addressing with frame-end pulse.
// Optional macro PIXEL_ARB_WRITE_PRIORITY_EN: writer always wins contention.
module pixel_buffer_arbiter #(
  parameter int NUM_PIXELS = 153600,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sop,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_rd_pend;
  logic              r_rd_oob;
  logic              r_frame_done;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
  logic              r_last_rd;    // 1: last grant went to the reader
`endif

  logic              w_grant_wr;
  logic              w_grant_rd;
  logic              w_rd_in_range;
  logic [ADDR_W-1:0] w_wr_issue_addr;
  logic [ADDR_W-1:0] w_wr_next_addr;

  assign w_rd_in_range   = ({1'b0, rd_addr} < DEPTH_EXT);
  assign w_wr_issue_addr = wr_sop ? ZERO_ADDR : r_wr_addr;
  assign w_wr_next_addr  = (w_wr_issue_addr == LAST_ADDR) ? ZERO_ADDR
                                                          : (w_wr_issue_addr + ADDR_W'(1));

  // Pick at most one requester per cycle; nobody is granted while in reset.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (reset) begin
      w_grant_wr = 1'b0;
      w_grant_rd = 1'b0;
    end else if (wr_valid && rd_valid) begin
`ifdef PIXEL_ARB_WRITE_PRIORITY_EN
      w_grant_wr = 1'b1;
`else
      if (r_last_rd) begin
        w_grant_wr = 1'b1;
      end else begin
        w_grant_rd = 1'b1;
      end
`endif
    end else if (wr_valid) begin
      w_grant_wr = 1'b1;
    end else if (rd_valid) begin
      w_grant_rd = 1'b1;
    end else begin
      w_grant_wr = 1'b0;
      w_grant_rd = 1'b0;
    end
  end

  assign wr_ready = w_grant_wr;
  assign rd_ready = w_grant_rd;

  // Drive the buffer port from the granted side; address holds when idle.
  always_comb begin
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_writedata  = wr_data;
    ram_address    = r_ram_addr;
    if (w_grant_wr) begin
      ram_chipselect = 1'b1;
      ram_write      = 1'b1;
      ram_address    = w_wr_issue_addr;
    end else if (w_grant_rd && w_rd_in_range) begin
      ram_chipselect = 1'b1;
      ram_address    = rd_addr;
    end else begin
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
    end
  end

  // Sequential state: write pointer, read tracking, frame pulse, arbitration history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr    <= ZERO_ADDR;
      r_ram_addr   <= ZERO_ADDR;
      r_rd_pend    <= 1'b0;
      r_rd_oob     <= 1'b0;
      r_frame_done <= 1'b0;
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
      r_last_rd    <= 1'b1;
`endif
    end else begin
      r_ram_addr   <= ram_address;
      r_rd_pend    <= w_grant_rd;
      r_rd_oob     <= w_grant_rd && !w_rd_in_range;
      r_frame_done <= w_grant_wr && !wr_sop && (r_wr_addr == LAST_ADDR);
      if (w_grant_wr) begin
        r_wr_addr <= w_wr_next_addr;
      end else begin
        r_wr_addr <= r_wr_addr;
      end
`ifndef PIXEL_ARB_WRITE_PRIORITY_EN
      if (w_grant_wr) begin
        r_last_rd <= 1'b0;
      end else if (w_grant_rd) begin
        r_last_rd <= 1'b1;
      end else begin
        r_last_rd <= r_last_rd;
      end
`endif
    end
  end

  // The buffer's 1-cycle read latency lines its output up with the pending
  // flag, so data is steered straight through; out-of-range reads return 0.
  // A read accepted just before reset is suppressed while reset is high.
  assign rd_data_valid = r_rd_pend && !reset;
  assign rd_data       = (r_rd_pend && !r_rd_oob && !reset) ? ram_readdata
                                                            : {DATA_W{1'b0}};
  assign wr_addr       = r_wr_addr;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_pixel_buffer_arbiter.sv
// Directed testbench for pixel_buffer_arbiter with a behavioural
// synchronous single-port RAM. A small buffer depth keeps the frame test short.
module tb_pixel_buffer_arbiter;

  localparam int NUM_PIXELS = 64;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_sop;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [0:NUM_PIXELS-1];

  pixel_buffer_arbiter #(
    .NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sop(wr_sop),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .wr_addr(wr_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) mem[ram_address[5:0]] <= ram_writedata;
      else           ram_readdata <= mem[ram_address[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_w;
    logic       prev_r;
    int         nw;
    ram_readdata = 8'h00;
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; wr_sop = 1'b0;
    rd_valid = 1'b0; rd_addr = 18'd0;

    // ---- reset state ----
    cyc(); cyc();
    check("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
    check("rst_rd_data",       32'(rd_data),       32'd0);
    check("rst_frame_done",    32'(frame_done),    32'd0);
    check("rst_wr_addr",       32'(wr_addr),       32'd0);
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    check("rst_wr_ready", 32'(wr_ready),       32'd0);
    check("rst_rd_ready", 32'(rd_ready),       32'd0);
    check("rst_cs",       32'(ram_chipselect), 32'd0);
    cyc();

    // ---- four writes starting with sop ----
    reset = 1'b0; rd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_sop = (k == 0); wr_data = 8'(8'h11 * (k + 1));
      #1;
      check("wr_ready",   32'(wr_ready),       32'd1);
      check("wr_cs",      32'(ram_chipselect), 32'd1);
      check("wr_we",      32'(ram_write),      32'd1);
      check("wr_addr_bus",32'(ram_address),    32'(k));
      check("wr_wdata",   32'(ram_writedata),  32'(8'h11 * (k + 1)));
      cyc();
    end
    wr_valid = 1'b0; wr_sop = 1'b0;
    #1;
    check("wr_addr_after4", 32'(wr_addr), 32'd4);

    // ---- single read of address 2 ----
    rd_valid = 1'b1; rd_addr = 18'd2;
    #1;
    check("rd_ready",   32'(rd_ready),       32'd1);
    check("rd_cs",      32'(ram_chipselect), 32'd1);
    check("rd_we",      32'(ram_write),      32'd0);
    check("rd_addr_bus",32'(ram_address),    32'd2);
    cyc();
    rd_valid = 1'b0;
    #1;
    check("rd_dv",   32'(rd_data_valid), 32'd1);
    check("rd_data", 32'(rd_data),       32'h33);
    cyc();
    check("rd_dv_drop", 32'(rd_data_valid), 32'd0);

    // ---- continuous contention from reset ----
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wr_valid = 1'b1; wr_sop = 1'b0; wr_data = 8'hA0;
    rd_valid = 1'b1; rd_addr = 18'd3;
    prev_r = 1'b0; nw = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef PIXEL_ARB_WRITE_PRIORITY_EN
      exp_w = 1'b1;
`else
      exp_w = ((i % 2) == 0);
`endif
      #1;
      check("cont_wr_ready", 32'(wr_ready),      32'(exp_w));
      check("cont_rd_ready", 32'(rd_ready),      32'(!exp_w));
      check("cont_rd_dv",    32'(rd_data_valid), 32'(prev_r));
      if (prev_r) check("cont_rd_data", 32'(rd_data), 32'h44);
      cyc();
      if (exp_w) begin
        wr_data = wr_data + 8'h01;
        nw++;
      end
      prev_r = !exp_w;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    #1;
    check("cont_rd_dv_last", 32'(rd_data_valid), 32'(prev_r));
    check("cont_wr_addr",    32'(wr_addr),       32'(nw));

    // ---- full frame stream ----
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < NUM_PIXELS + 2; i++) begin
      wr_valid = (i < NUM_PIXELS); wr_sop = (i == 0); wr_data = 8'(i);
      #1;
      check("frame_done", 32'(frame_done), 32'(i == NUM_PIXELS));
      if (i < NUM_PIXELS) begin
        check("frame_wr_ready", 32'(wr_ready),    32'd1);
        check("frame_addr",     32'(ram_address), 32'(i));
      end
      cyc();
    end
    wr_sop = 1'b0;
    #1;
    check("frame_wrap_wr_addr", 32'(wr_addr), 32'd0);

    // ---- sop on the last-address beat suppresses frame_done ----
    for (int j = 0; j < NUM_PIXELS - 1; j++) begin
      wr_valid = 1'b1; wr_data = 8'(j);
      cyc();
    end
    wr_sop = 1'b1;
    #1;
    check("sop_last_wr_addr", 32'(wr_addr),     32'(NUM_PIXELS - 1));
    check("sop_last_bus",     32'(ram_address), 32'd0);
    cyc();
    wr_valid = 1'b0; wr_sop = 1'b0;
    #1;
    check("sop_last_no_done", 32'(frame_done), 32'd0);
    check("sop_last_next",    32'(wr_addr),    32'd1);

    // ---- out-of-range reads ----
    rd_valid = 1'b1; rd_addr = 18'(NUM_PIXELS);
    #1;
    check("oob_rd_ready", 32'(rd_ready),       32'd1);
    check("oob_cs",       32'(ram_chipselect), 32'd0);
    cyc();
    rd_addr = 18'd153600;
    #1;
    check("oob_dv",        32'(rd_data_valid),  32'd1);
    check("oob_data",      32'(rd_data),        32'd0);
    check("oob2_rd_ready", 32'(rd_ready),       32'd1);
    check("oob2_cs",       32'(ram_chipselect), 32'd0);
    cyc();
    rd_valid = 1'b0;
    #1;
    check("oob2_dv",   32'(rd_data_valid), 32'd1);
    check("oob2_data", 32'(rd_data),       32'd0);
    check("idle_cs",   32'(ram_chipselect),32'd0);
    check("idle_we",   32'(ram_write),     32'd0);
    check("idle_hold", 32'(ram_address),   32'd0);
    cyc();
    check("oob_dv_drop", 32'(rd_data_valid), 32'd0);

    // ---- reset right after an accepted read ----
    rd_valid = 1'b1; rd_addr = 18'd5;
    #1;
    check("mid_rd_ready", 32'(rd_ready), 32'd1);
    cyc();
    reset = 1'b1; wr_valid = 1'b1;
    #1;
    check("mid_dv",       32'(rd_data_valid), 32'd0);
    check("mid_rd_data",  32'(rd_data),       32'd0);
    check("mid_wr_ready", 32'(wr_ready),      32'd0);
    check("mid_rd_ready", 32'(rd_ready),      32'd0);
    cyc();
    check("mid_wr_addr", 32'(wr_addr),       32'd0);
    check("mid_dv2",     32'(rd_data_valid), 32'd0);
    reset = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
